serial_add_ctrl: RTL and testbench

//  Sequencer for a bit-serial adder built around a single carry flip-flop.
//  - Latches two WIDTH-bit operands into shift registers.
//  - Steps them LSB-first through a 1-bit full adder for WIDTH cycles.
//  - Assembles the sum, then signals completion with a one-cycle done pulse.

---
 rtl/serial_add_ctrl_pkg.sv | 26 ++
 rtl/serial_add_ctrl_if.sv | 31 +++
 rtl/serial_fa_cell.sv | 42 ++++
 rtl/serial_add_ctrl.sv | 127 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the bit-serial adder sequencer:
//   - state encoding (S_IDLE / S_SHIFT / S_DONE) and the matching enum type
//   - default operand width
//   - majority() helper used as the full-adder carry function
// -----------------------------------------------------------------------------
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_SHIFT = S_SHIFT,
        ST_DONE  = S_DONE
    } state_t;

    function automatic logic majority(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_if
// Host <-> sequencer bundle for the bit-serial adder.
//   start, a, b, sub          : request and operands (host drives)
//   sum, cout, overflow       : result (sequencer drives, valid with done)
//   busy, done                : status (sequencer drives)
// Modports: master = host side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, sub,
        input  sum, cout, overflow, busy, done
    );

    modport slave (
        input  start, a, b, sub,
        output sum, cout, overflow, busy, done
    );
endinterface

// File: rtl/serial_fa_cell.sv
// -----------------------------------------------------------------------------
// serial_fa_cell
// One-bit full adder with its carry flip-flop: the whole arithmetic datapath
// of the serial adder.
//   clk, rst   : clock, synchronous active-high reset (clears carry)
//   load       : preset carry to carry_in (start of an operation)
//   carry_in   : preset value (1 for two's-complement subtract)
//   en         : advance one bit: carry <= carry_out
//   a, b       : current operand bits
//   s          : sum bit (combinational)
//   carry_out  : carry produced by this bit (combinational)
//   carry_q    : stored carry, i.e. carry into the current bit
// -----------------------------------------------------------------------------
module serial_fa_cell
    import serial_add_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic carry_in,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic s,
    output logic carry_out,
    output logic carry_q
);

    assign s         = a ^ b ^ carry_q;
    assign carry_out = majority(a, b, carry_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q <= 1'b0;
        end else if (load) begin
            carry_q <= carry_in;
        end else if (en) begin
            carry_q <= carry_out;
        end
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Sequencer for a bit-serial adder. On an accepted start it latches both
// operands, steps them LSB-first through serial_fa_cell for WIDTH cycles,
// assembles the sum and pulses done for one cycle.
// Ports:
//   clk  : clock (posedge)
//   rst  : synchronous active-high reset; aborts any operation
//   bus  : serial_add_ctrl_if.slave (start/a/b/sub in; sum/cout/overflow/
//          busy/done out)
// Build option: define SERIAL_SUB_EN to honour bus.sub (A-B via ~b and a
// carry preset of 1). Without it the block only adds and sub is ignored.
// -----------------------------------------------------------------------------
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    serial_add_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state, state_nxt;
    logic               load, step, last;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_sr, b_sr, sum_q;
    logic [WIDTH-1:0]   b_load;
    logic               carry_preset;
    logic               cout_q, ovf_q;
    logic               s_bit, carry_out, carry_q;

`ifdef SERIAL_SUB_EN
    assign b_load       = bus.sub ? ~bus.b : bus.b;
    assign carry_preset = bus.sub;
`else
    logic unused_sub;
    assign unused_sub   = bus.sub;
    assign b_load       = bus.b;
    assign carry_preset = 1'b0;
`endif

    assign last = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bus.busy = 1'b1;
                step     = 1'b1;
                if (last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.done  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    serial_fa_cell u_fa (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .carry_in  (carry_preset),
        .en        (step),
        .a         (a_sr[0]),
        .b         (b_sr[0]),
        .s         (s_bit),
        .carry_out (carry_out),
        .carry_q   (carry_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (load) begin
            a_sr <= bus.a;
            b_sr <= b_load;
            cnt  <= '0;
        end else if (step) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            cnt   <= cnt + CNT_W'(1);
            // New bit enters at the MSB; after WIDTH steps the first bit is at bit 0.
            // Written as shift/or so WIDTH=1 needs no special case.
            sum_q <= (sum_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
            if (last) begin
                // carry_q here is the carry into the MSB.
                cout_q <= carry_out;
                ovf_q  <= carry_q ^ carry_out;
            end
        end
    end

    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed cases plus
// randomized operands compared against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   tests_run = 0;
    int   tests_failed = 0;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the effective operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         output logic [W-1:0] s, output logic c, output logic v);
        logic          use_sub;
        logic [W-1:0]  bb;
        logic [W:0]    full;
`ifdef SERIAL_SUB_EN
        use_sub = sub;
`else
        use_sub = 1'b0;
`endif
        bb   = use_sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, use_sub};
        s    = full[W-1:0];
        c    = full[W];
        v    = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
    endtask

    // Issues one operation and checks latency, busy length and result.
    // poke_at >= 0 re-asserts start with other operands that many cycles in.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input int poke_at,
                          output logic [W-1:0] rs, output logic rc, output logic rv);
        logic [W-1:0] es;
        logic         ec, ev;
        int           busy_cnt, lat;
        bit           seen, both;
        model(a, b, sub, es, ec, ev);
        bus.a = a; bus.b = b; bus.sub = sub; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        busy_cnt = 0; lat = 0; seen = 0; both = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy && bus.done) both = 1;
            if (bus.done) begin
                seen = 1;
                break;
            end
            if (bus.busy) busy_cnt++;
            if (i == poke_at) begin
                bus.start = 1'b1; bus.a = 8'h11; bus.b = 8'h11; bus.sub = ~sub;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            lat++;
        end
        bus.start = 1'b0;
        check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
        check_eq({tag, "_latency"}, lat, W);
        check_eq({tag, "_busy_cycles"}, busy_cnt, W);
        check_eq({tag, "_busy_done_overlap"}, 32'(both), 32'd0);
        check_eq({tag, "_sum"}, 32'(bus.sum), 32'(es));
        check_eq({tag, "_cout"}, 32'(bus.cout), 32'(ec));
        check_eq({tag, "_ovf"}, 32'(bus.overflow), 32'(ev));
        rs = bus.sum; rc = bus.cout; rv = bus.overflow;
        tick();
        check_eq({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
        tick();
        check_eq({tag, "_sum_held"}, 32'(bus.sum), 32'(es));
        check_eq({tag, "_no_second_done"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        logic [W-1:0] rs, ra, rb;
        logic         rc, rv, rsub;
        logic [W-1:0] es;
        logic         ec, ev;
        bit           got_done;

        rst = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0;
        tick(); tick();
        check_eq("rst_sum", 32'(bus.sum), 32'd0);
        check_eq("rst_cout", 32'(bus.cout), 32'd0);
        check_eq("rst_ovf", 32'(bus.overflow), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        tick();

        // Directed cases with hand-computed results.
        run_op("t1", 8'h5A, 8'h33, 1'b0, -1, rs, rc, rv);
        check_eq("t1_const", {23'd0, rs, rc}, {23'd0, 8'h8D, 1'b0});
        check_eq("t1_ovf_const", 32'(rv), 32'd1);
        run_op("t2a", 8'hFF, 8'h01, 1'b0, -1, rs, rc, rv);
        check_eq("t2a_const", {22'd0, rs, rc, rv}, {22'd0, 8'h00, 1'b1, 1'b0});
        run_op("t2b", 8'h00, 8'h00, 1'b0, -1, rs, rc, rv);
        check_eq("t2b_const", {22'd0, rs, rc, rv}, {22'd0, 8'h00, 1'b0, 1'b0});

        // Start re-issued mid-operation is ignored.
        run_op("t3", 8'h5A, 8'h33, 1'b0, 2, rs, rc, rv);
        check_eq("t3_first_pair", 32'(rs), 32'h8D);

`ifdef SERIAL_SUB_EN
        run_op("t5a", 8'h10, 8'h20, 1'b1, -1, rs, rc, rv);
        check_eq("t5a_const", {23'd0, rs, rc}, {23'd0, 8'hF0, 1'b0});
        run_op("t5b", 8'h80, 8'h01, 1'b1, -1, rs, rc, rv);
        check_eq("t5b_const", {22'd0, rs, rc, rv}, {22'd0, 8'h7F, 1'b1, 1'b1});
`endif

        // Reset in the middle of SHIFT.
        bus.a = 8'hC3; bus.b = 8'h7E; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        check_eq("t4_busy", 32'(bus.busy), 32'd0);
        check_eq("t4_sum", 32'(bus.sum), 32'd0);
        check_eq("t4_done", 32'(bus.done), 32'd0);
        check_eq("t4_cout_ovf", {30'd0, bus.cout, bus.overflow}, 32'd0);
        rst = 1'b0;
        got_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done || bus.busy) got_done = 1;
        end
        check_eq("t4_no_activity", 32'(got_done), 32'd0);
        run_op("t4_fresh", 8'h12, 8'h34, 1'b0, -1, rs, rc, rv);

        // Randomized operands.
        for (int n = 0; n < 20; n++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rsub = 1'($urandom);
            run_op($sformatf("rnd%0d", n), ra, rb, rsub, -1, rs, rc, rv);
        end

        // start held high: accepted every WIDTH+2 cycles.
        ra = 8'hA7; rb = 8'h6C;
        model(ra, rb, 1'b0, es, ec, ev);
        bus.a = ra; bus.b = rb; bus.sub = 1'b0; bus.start = 1'b1;
        for (int t = 0; t < 30; t++) begin
            tick();
            check_eq($sformatf("t6_busy_%0d", t), 32'(bus.busy), 32'((t % 10) < W));
            check_eq($sformatf("t6_done_%0d", t), 32'(bus.done), 32'((t % 10) == W));
            if ((t % 10) == W)
                check_eq($sformatf("t6_sum_%0d", t), {23'd0, bus.sum, bus.cout}, {23'd0, es, ec});
        end
        bus.start = 1'b0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
